// File: rtl/store_wb_buffer_pkg.sv
// Shared types for the post-retire store write buffer.
// WB_DEPTH defaults through a `define so the whole slice can be resized from the build line.
`ifndef WB_DEPTH
`define WB_DEPTH 8
`endif

package store_wb_buffer_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [3:0]      usebytes;
  } SQ_ENTRY_PACKET;

  typedef enum logic [1:0] {WB_IDLE, WB_REQ, WB_WAIT} WB_STATE;

  // Lane 0 is the youngest retire lane, so it is the first to be held back.
  function automatic logic [2:0] stall_from_free(input int free);
    if (free >= 3)      return 3'b000;
    else if (free == 2) return 3'b001;
    else if (free == 1) return 3'b011;
    else                return 3'b111;
  endfunction

  function automatic logic word_match(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return ((a ^ b) >> 2) == '0;
  endfunction

endpackage

// File: rtl/store_wb_buffer_if.sv
// Retire-side, load-forwarding and D-cache write-port signals of the store write buffer.
// The buffer itself connects through the slave modport.
interface store_wb_buffer_if;
  import store_wb_buffer_pkg::*;

  logic [2:0]           wb_in_valid;
  SQ_ENTRY_PACKET [2:0] wb_in;
  logic [2:0]           wb_stall;
  logic [XLEN-1:0]      ld_addr;
  logic [3:0]           ld_usebytes;
  logic [XLEN-1:0]      ld_data;
  logic                 ld_stall;
  logic                 dc_req_valid;
  logic [XLEN-1:0]      dc_req_addr;
  logic [XLEN-1:0]      dc_req_data;
  logic [3:0]           dc_req_usebytes;
  logic                 dc_accept;
  logic                 dc_done;
  logic                 wb_empty;

  modport master (
    output wb_in_valid, wb_in, ld_addr, dc_accept, dc_done,
    input  wb_stall, ld_usebytes, ld_data, ld_stall,
           dc_req_valid, dc_req_addr, dc_req_data, dc_req_usebytes, wb_empty
  );

  modport slave (
    input  wb_in_valid, wb_in, ld_addr, dc_accept, dc_done,
    output wb_stall, ld_usebytes, ld_data, ld_stall,
           dc_req_valid, dc_req_addr, dc_req_data, dc_req_usebytes, wb_empty
  );
endinterface

// File: rtl/store_wb_buffer_fwd_match.sv
// Age-ordered byte select over the valid write-buffer entries for load forwarding.
// Only instantiated when WB_FORWARD_EN is defined.
module wb_fwd_match
  import store_wb_buffer_pkg::*;
#(
  parameter int WB_DEPTH = `WB_DEPTH,
  parameter int WB_IDX_W = $clog2(WB_DEPTH)
) (
  input  SQ_ENTRY_PACKET      entries [WB_DEPTH],
  input  logic [WB_IDX_W-1:0] head,
  input  logic [WB_IDX_W:0]   count,
  input  logic [XLEN-1:0]     ld_addr,
  output logic [3:0]          usebytes,
  output logic [XLEN-1:0]     data
);

  SQ_ENTRY_PACKET      aged [WB_DEPTH];
  logic [WB_DEPTH-1:0] hit;

  // aged[0] is the head (oldest); higher indices are younger.
  for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_age
    assign aged[gi] = entries[head + WB_IDX_W'(gi)];
    assign hit[gi]  = ((WB_IDX_W+1)'(gi) < count) && word_match(aged[gi].addr, ld_addr);
  end

  // Later (younger) matches overwrite earlier ones byte by byte.
  always_comb begin
    usebytes = '0;
    data     = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (hit[k] && aged[k].usebytes[b]) begin
          usebytes[b]    = 1'b1;
          data[8*b +: 8] = aged[k].data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/store_wb_buffer.sv
// Post-retire store write buffer: 3-lane enqueue FIFO, single-store D-cache drain FSM, load forwarding.
// WB_FORWARD_EN selects byte forwarding; without it a matching load is stalled instead.
module store_wb_buffer
  import store_wb_buffer_pkg::*;
#(
  parameter int WB_DEPTH = `WB_DEPTH,
  parameter int WB_IDX_W = $clog2(WB_DEPTH)
) (
  input logic              clock,
  input logic              reset,
  store_wb_buffer_if.slave bus
);

  SQ_ENTRY_PACKET      entries [WB_DEPTH];
  SQ_ENTRY_PACKET      head_entry;
  logic [WB_IDX_W-1:0] head_reg, tail_reg;
  logic [WB_IDX_W:0]   count_reg, count_next, free;
  WB_STATE             state_reg, state_next;
  logic [2:0]          lane_we;
  logic [1:0]          lane_off [3];
  logic [1:0]          n_enq;
  logic [WB_IDX_W-1:0] lane_slot [3];
  logic                pop;

  assign head_entry   = entries[head_reg];
  assign free         = (WB_IDX_W+1)'(WB_DEPTH) - count_reg;
  assign bus.wb_stall = stall_from_free(int'(free));
  assign lane_we      = bus.wb_in_valid & ~bus.wb_stall;
  assign pop          = ((state_reg == WB_REQ) && bus.dc_accept && bus.dc_done) ||
                        ((state_reg == WB_WAIT) && bus.dc_done);
  assign count_next   = count_reg + (WB_IDX_W+1)'(n_enq) - (WB_IDX_W+1)'(pop);

  // Lanes pack into consecutive slots in the order 2, 1, 0.
  always_comb begin
    lane_off[2] = 2'd0;
    lane_off[1] = {1'b0, lane_we[2]};
    lane_off[0] = lane_off[1] + {1'b0, lane_we[1]};
    n_enq       = lane_off[0] + {1'b0, lane_we[0]};
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    assign lane_slot[gi] = tail_reg + WB_IDX_W'(lane_off[gi]);
  end

  always_ff @(posedge clock) begin
    for (int l = 0; l < 3; l++) begin
      if (lane_we[l]) entries[lane_slot[l]] <= bus.wb_in[l];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + WB_IDX_W'(pop);
      tail_reg  <= tail_reg + WB_IDX_W'(n_enq);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= WB_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WB_IDLE: if (count_reg != '0) state_next = WB_REQ;
      WB_REQ: begin
        if (pop)                state_next = (count_next != '0) ? WB_REQ : WB_IDLE;
        else if (bus.dc_accept) state_next = WB_WAIT;
      end
      WB_WAIT: if (pop) state_next = (count_next != '0) ? WB_REQ : WB_IDLE;
      default: state_next = WB_IDLE;
    endcase
  end

  // Request fields are zeroed outside REQ so nothing stale leaks after reset.
  always_comb begin
    bus.dc_req_valid    = 1'b0;
    bus.dc_req_addr     = '0;
    bus.dc_req_data     = '0;
    bus.dc_req_usebytes = '0;
    if (state_reg == WB_REQ) begin
      bus.dc_req_valid    = 1'b1;
      bus.dc_req_addr     = head_entry.addr;
      bus.dc_req_data     = head_entry.data;
      bus.dc_req_usebytes = head_entry.usebytes;
    end
    bus.wb_empty = (count_reg == '0) && (state_reg == WB_IDLE);
  end

`ifdef WB_FORWARD_EN
  wb_fwd_match #(
    .WB_DEPTH (WB_DEPTH),
    .WB_IDX_W (WB_IDX_W)
  ) u_fwd (
    .entries  (entries),
    .head     (head_reg),
    .count    (count_reg),
    .ld_addr  (bus.ld_addr),
    .usebytes (bus.ld_usebytes),
    .data     (bus.ld_data)
  );
  assign bus.ld_stall = 1'b0;
`else
  logic [WB_DEPTH-1:0] word_hit;

  for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_hit
    logic [WB_IDX_W-1:0] idx;
    assign idx          = head_reg + WB_IDX_W'(gi);
    assign word_hit[gi] = ((WB_IDX_W+1)'(gi) < count_reg) &&
                          word_match(entries[idx].addr, bus.ld_addr);
  end

  assign bus.ld_stall    = |word_hit;
  assign bus.ld_usebytes = '0;
  assign bus.ld_data     = '0;
`endif

  a_no_stalled_enqueue: assert property (@(posedge clock) disable iff (reset)
    (bus.wb_in_valid & bus.wb_stall) == 3'b000);

endmodule

// File: tb/tb_store_wb_buffer.sv
// Directed bench for store_wb_buffer: vector table for fill/drain, hand sequences for full/wrap/forward/reset.
// Expectations follow WB_FORWARD_EN if the bench is built with it.
module tb_store_wb_buffer;
  import store_wb_buffer_pkg::*;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  store_wb_buffer_if bus ();

  store_wb_buffer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  vld;
    logic [31:0] a2, d2, a1, d1, a0, d0;
    logic        acc, done;
    logic [2:0]  e_stall;
    logic        e_req;
    logic [31:0] e_addr, e_data;
    logic        e_empty;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] d, input logic [3:0] ub);
    bus.wb_in[l] = '{addr: a, data: d, usebytes: ub};
  endtask

  task automatic quiet();
    bus.wb_in_valid = 3'b000;
    bus.dc_accept   = 1'b0;
    bus.dc_done     = 1'b0;
  endtask

  function automatic vec_t mk(input logic [2:0] vld, input logic [31:0] a2, d2, a1, d1, a0, d0,
                              input logic acc, done, input logic [2:0] es, input logic er,
                              input logic [31:0] ea, ed, input logic ee);
    vec_t v;
    v.vld = vld; v.a2 = a2; v.d2 = d2; v.a1 = a1; v.d1 = d1; v.a0 = a0; v.d0 = d0;
    v.acc = acc; v.done = done; v.e_stall = es; v.e_req = er;
    v.e_addr = ea; v.e_data = ed; v.e_empty = ee;
    return v;
  endfunction

  function automatic logic [31:0] ea(input int k);
    return 32'h200 + 32'(4 * k);
  endfunction

  function automatic logic [31:0] ed(input int k);
    return 32'hD000_0000 + 32'(k);
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Fill A, fill B, hold REQ, accept, WAIT x3, done, then back-to-back pops.
    vecs[0]  = mk(3'b111, 32'h10, 32'h20, 32'h28, 32'h38, 32'h78, 32'h88, 0, 0, 3'b000, 0, 32'h0, 32'h0, 0);
    vecs[1]  = mk(3'b111, 32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208, 0, 0, 3'b001, 1, 32'h10, 32'h20, 0);
    for (int i = 2; i <= 5; i++)
      vecs[i] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 1, 32'h10, 32'h20, 0);
    vecs[6]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 3'b001, 0, 32'h0, 32'h0, 0);
    vecs[7]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 32'h0, 32'h0, 0);
    vecs[8]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 32'h0, 32'h0, 0);
    vecs[9]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 1, 32'h28, 32'h38, 0);
    vecs[10] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 3'b000, 1, 32'h78, 32'h88, 0);
    vecs[11] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 3'b000, 1, 32'h100, 32'h200, 0);
    vecs[12] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 3'b000, 1, 32'h104, 32'h204, 0);
    vecs[13] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 3'b000, 1, 32'h108, 32'h208, 0);
    vecs[14] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 3'b000, 0, 32'h0, 32'h0, 1);

    reset = 1'b1;
    quiet();
    bus.ld_addr = 32'h0;
    for (int l = 0; l < 3; l++) set_lane(l, 32'h0, 32'h0, 4'h0);
    repeat (2) cyc();

    check("reset_empty", 64'(bus.wb_empty), 64'(1'b1));
    check("reset_stall", 64'(bus.wb_stall), 64'(3'b000));
    check("reset_req_valid", 64'(bus.dc_req_valid), 64'(1'b0));
    check("reset_ld_stall", 64'(bus.ld_stall), 64'(1'b0));
    check("reset_ld_usebytes", 64'(bus.ld_usebytes), 64'(4'h0));
    reset = 1'b0;
    cyc();
    check("idle_empty", 64'(bus.wb_empty), 64'(1'b1));

    for (int i = 0; i < 15; i++) begin
      bus.wb_in_valid = vecs[i].vld;
      set_lane(2, vecs[i].a2, vecs[i].d2, 4'hF);
      set_lane(1, vecs[i].a1, vecs[i].d1, 4'hF);
      set_lane(0, vecs[i].a0, vecs[i].d0, 4'hF);
      bus.dc_accept = vecs[i].acc;
      bus.dc_done   = vecs[i].done;
      cyc();
      $display("vec %0d: stall=%b req=%b addr=%h data=%h empty=%b", i,
               bus.wb_stall, bus.dc_req_valid, bus.dc_req_addr, bus.dc_req_data, bus.wb_empty);
      check($sformatf("vec%0d_stall", i), 64'(bus.wb_stall), 64'(vecs[i].e_stall));
      check($sformatf("vec%0d_req_valid", i), 64'(bus.dc_req_valid), 64'(vecs[i].e_req));
      check($sformatf("vec%0d_req_addr", i), 64'(bus.dc_req_addr), 64'(vecs[i].e_addr));
      check($sformatf("vec%0d_req_data", i), 64'(bus.dc_req_data), 64'(vecs[i].e_data));
      check($sformatf("vec%0d_empty", i), 64'(bus.wb_empty), 64'(vecs[i].e_empty));
    end
    quiet();

    // Full buffer, pop with simultaneous enqueue, tail wrap.
    bus.wb_in_valid = 3'b111;
    set_lane(2, ea(0), ed(0), 4'hF); set_lane(1, ea(1), ed(1), 4'hF); set_lane(0, ea(2), ed(2), 4'hF);
    cyc();
    set_lane(2, ea(3), ed(3), 4'hF); set_lane(1, ea(4), ed(4), 4'hF); set_lane(0, ea(5), ed(5), 4'hF);
    cyc();
    check("fill6_stall", 64'(bus.wb_stall), 64'(3'b001));
    bus.wb_in_valid = 3'b110;
    set_lane(2, ea(6), ed(6), 4'hF); set_lane(1, ea(7), ed(7), 4'hF);
    cyc();
    $display("full: stall=%b req_addr=%h", bus.wb_stall, bus.dc_req_addr);
    check("full_stall", 64'(bus.wb_stall), 64'(3'b111));
    check("full_head_addr", 64'(bus.dc_req_addr), 64'(ea(0)));
    quiet();
    cyc();
    check("full_hold_stall", 64'(bus.wb_stall), 64'(3'b111));
    check("full_hold_addr", 64'(bus.dc_req_addr), 64'(ea(0)));
    bus.dc_accept = 1'b1; bus.dc_done = 1'b1;
    cyc();
    check("pop7_stall", 64'(bus.wb_stall), 64'(3'b011));
    check("pop7_addr", 64'(bus.dc_req_addr), 64'(ea(1)));
    bus.wb_in_valid = 3'b100;
    set_lane(2, ea(8), ed(8), 4'hF);
    cyc();
    $display("pop+enq: stall=%b req_addr=%h", bus.wb_stall, bus.dc_req_addr);
    check("popenq_stall", 64'(bus.wb_stall), 64'(3'b011));
    check("popenq_addr", 64'(bus.dc_req_addr), 64'(ea(2)));
    bus.dc_accept = 1'b0; bus.dc_done = 1'b0;
    set_lane(2, ea(9), ed(9), 4'hF);
    cyc();
    check("refull_stall", 64'(bus.wb_stall), 64'(3'b111));
    quiet();
    for (int k = 2; k <= 9; k++) begin
      check($sformatf("drain%0d_addr", k), 64'(bus.dc_req_addr), 64'(ea(k)));
      check($sformatf("drain%0d_data", k), 64'(bus.dc_req_data), 64'(ed(k)));
      bus.dc_accept = 1'b1; bus.dc_done = 1'b1;
      cyc();
    end
    quiet();
    check("drained_empty", 64'(bus.wb_empty), 64'(1'b1));
    check("drained_req_valid", 64'(bus.dc_req_valid), 64'(1'b0));

    // Forwarding / load-stall over two overlapping stores to word 0x38.
    bus.wb_in_valid = 3'b110;
    set_lane(2, 32'h38, 32'hAAAA_AAAA, 4'b1111);
    set_lane(1, 32'h38, 32'h0000_5555, 4'b0011);
    bus.ld_addr = 32'h38;
    #1;
    check("fwd_same_cycle_stall", 64'(bus.ld_stall), 64'(1'b0));
    check("fwd_same_cycle_bytes", 64'(bus.ld_usebytes), 64'(4'h0));
    cyc();
    quiet();
    #1;
    $display("load 38: stall=%b usebytes=%b data=%h", bus.ld_stall, bus.ld_usebytes, bus.ld_data);
`ifdef WB_FORWARD_EN
    check("fwd38_bytes", 64'(bus.ld_usebytes), 64'(4'b1111));
    check("fwd38_data", 64'(bus.ld_data), 64'(32'hAAAA_5555));
    check("fwd38_stall", 64'(bus.ld_stall), 64'(1'b0));
    bus.ld_addr = 32'h3A; #1;
    check("fwd3a_data", 64'(bus.ld_data), 64'(32'hAAAA_5555));
`else
    check("ldst38_stall", 64'(bus.ld_stall), 64'(1'b1));
    check("ldst38_bytes", 64'(bus.ld_usebytes), 64'(4'h0));
    check("ldst38_data", 64'(bus.ld_data), 64'(32'h0));
    bus.ld_addr = 32'h3A; #1;
    check("ldst3a_stall", 64'(bus.ld_stall), 64'(1'b1));
`endif
    bus.ld_addr = 32'h3C; #1;
    check("ld3c_bytes", 64'(bus.ld_usebytes), 64'(4'h0));
    check("ld3c_stall", 64'(bus.ld_stall), 64'(1'b0));
    bus.ld_addr = 32'h38;
    cyc();
    bus.dc_accept = 1'b1; bus.dc_done = 1'b1;
    cyc();
`ifdef WB_FORWARD_EN
    check("fwd_pop1_bytes", 64'(bus.ld_usebytes), 64'(4'b0011));
    check("fwd_pop1_data", 64'(bus.ld_data), 64'(32'h0000_5555));
`else
    check("ldst_pop1_stall", 64'(bus.ld_stall), 64'(1'b1));
`endif
    cyc();
    quiet();
    check("ld_pop2_stall", 64'(bus.ld_stall), 64'(1'b0));
    check("ld_pop2_bytes", 64'(bus.ld_usebytes), 64'(4'h0));
    check("ld_pop2_empty", 64'(bus.wb_empty), 64'(1'b1));

    // Reset while a request is outstanding drops it at once.
    bus.wb_in_valid = 3'b100;
    set_lane(2, 32'h400, 32'h1234_5678, 4'hF);
    cyc();
    quiet();
    cyc();
    check("midreq_valid", 64'(bus.dc_req_valid), 64'(1'b1));
    reset = 1'b1;
    #1;
    $display("mid-drain reset: req=%b empty=%b", bus.dc_req_valid, bus.wb_empty);
    check("midreset_req_valid", 64'(bus.dc_req_valid), 64'(1'b0));
    check("midreset_empty", 64'(bus.wb_empty), 64'(1'b1));
    cyc();
    reset = 1'b0;
    cyc();
    check("post_reset_empty", 64'(bus.wb_empty), 64'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
